uart_mem_bridge: RTL and testbench
==================================

UART_MEM_BRIDGE -- requirements
Module: uart_mem_bridge

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_W, 16, memory address width.
- RX_BYTES, 16384, bytes loaded from UART per frame (1..2^ADDR_W).
- TX_BYTES, 4096, bytes returned over UART per frame (1..2^ADDR_W).
- TX_BASE, 16384, first memory address read for transmission (TX_BASE+TX_BYTES <= 2^ADDR_W).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock, all logic on rising edge.
- reset, in, 1, asynchronous, active-high reset.
- rx_ready, in, 1, UART receiver byte-available flag; may stay high for more than one cycle.
- rx_data, in, 8, received byte, valid while rx_ready is high.
- tx_busy, in, 1, UART transmitter busy.
- tx_wr_en, out, 1, one-cycle transmit strobe.
- tx_data, out, 8, byte to transmit, held stable from the tx_wr_en cycle until the next strobe.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, 8, memory write data.
- mem_we, out, 1, memory write enable.
- mem_rdata, in, 8, memory read data, valid 1 cycle after mem_addr.
- proc_start, out, 1, one-cycle pulse that starts the downsampling processor.
- proc_done, in, 1, processor completion; level or pulse.
- phase, out, 3, current state encoding (see REQ-004).

Function
REQ-003 SHALL register all outputs; no combinational path from any input to any output.
REQ-004 SHALL implement the states IDLE=0, RX_LOAD=1, PROC=2, TX_FETCH=3, TX_SEND=4, TX_WAIT=5; phase SHALL equal the current state.
REQ-005 SHALL detect a new byte only on a rising edge of rx_ready (registered previous value); a level held high counts once.
REQ-006 IDLE: on the first rx_ready edge, SHALL write that byte to address 0, set byte count to 1, and go to RX_LOAD, or to PROC if RX_BYTES==1.
REQ-007 RX_LOAD: each rx_ready edge SHALL produce exactly one cycle of mem_we=1, with mem_addr=count and mem_wdata=rx_data, in the cycle after the edge is sampled; the count then increments.
REQ-008 When the write of byte RX_BYTES-1 is issued, the block SHALL go to PROC and pulse proc_start for exactly one cycle on entry.
REQ-009 PROC: the block SHALL ignore rx_ready edges and drop those bytes; on proc_done=1 it SHALL go to TX_FETCH with tx index 0.
REQ-010 TX_FETCH: the block SHALL drive mem_addr=TX_BASE+index for one cycle, then go to TX_SEND.
REQ-011 TX_SEND: the block SHALL capture mem_rdata into tx_data; when tx_busy==0 it SHALL pulse tx_wr_en for one cycle and go to TX_WAIT; while tx_busy==1 it SHALL hold with no strobe.
REQ-012 TX_WAIT: the block SHALL ignore tx_busy for 2 guard cycles, then wait for tx_busy==0.
REQ-013 At the end of TX_WAIT, the block SHALL increment index; if index reached TX_BYTES it SHALL go to IDLE, otherwise to TX_FETCH.
REQ-014 The block SHALL drop rx_ready edges in every state other than IDLE and RX_LOAD.
REQ-015 Address arithmetic SHALL be ADDR_W bits wide and SHALL wrap modulo 2^ADDR_W; counters SHALL be ADDR_W+1 bits so that RX_BYTES=2^ADDR_W terminates.
REQ-016 mem_we and tx_wr_en SHALL never be high in the same cycle; mem_we SHALL be 0 in every state except RX_LOAD and the IDLE first-byte write.
REQ-017 A proc_done that is already high on PROC entry SHALL be accepted one cycle after proc_start.

Reset
REQ-018 While reset=1, regardless of clk, the block SHALL force state IDLE, counters 0, rx_ready history 0, and all outputs 0.
REQ-019 A reset asserted mid-frame SHALL abort the frame without issuing any further mem_we or tx_wr_en; after release the next rx_ready edge SHALL be treated as byte 0 of a new frame.

Verification
REQ-020 The bench SHALL cover these scenarios (RX_BYTES=4, TX_BYTES=2, TX_BASE=8):
- Bytes 0x11,0x22,0x33,0x44 -> writes at addresses 0..3 with that data, then one proc_start pulse.
- rx_ready held high for 5 cycles per byte -> exactly one write per byte.
- proc_done after 10 cycles, memory[8]=0xA5, memory[9]=0x5A -> tx_wr_en with tx_data 0xA5 then 0x5A, then phase=0.
- tx_busy held high for 20 cycles after each strobe -> no second strobe until tx_busy=0; still 2 strobes total.
- Byte sent during PROC -> no mem_we, and the frame still completes.
- reset pulsed after 2 received bytes -> outputs 0 immediately; the next byte is written to address 0.

Source files
------------

// File: rtl/uart_mem_bridge.sv
// UART-to-memory bridge: loads a frame of received bytes into memory, kicks a
// processor, then streams a result window back out through the UART transmitter.
module uart_mem_bridge #(
    parameter int ADDR_W   = 16,
    parameter int RX_BYTES = 16384,
    parameter int TX_BYTES = 4096,
    parameter int TX_BASE  = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_wr_en,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              proc_start,
    input  logic              proc_done,
    output logic [2:0]        phase
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_LOAD  = 3'd1,
        PROC     = 3'd2,
        TX_FETCH = 3'd3,
        TX_SEND  = 3'd4,
        TX_WAIT  = 3'd5
    } state_t;

    localparam logic [ADDR_W:0]   RX_N      = (ADDR_W+1)'(RX_BYTES);
    localparam logic [ADDR_W:0]   TX_N      = (ADDR_W+1)'(TX_BYTES);
    localparam logic [ADDR_W:0]   ONE       = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] TX_BASE_A = ADDR_W'(TX_BASE);

    state_t              state_reg, state_next;
    logic                rx_prev_reg;
    logic [ADDR_W:0]     count_reg, count_next;
    logic [ADDR_W:0]     idx_reg, idx_next;
    logic [1:0]          guard_reg, guard_next;
    logic                tx_wr_en_reg, tx_wr_en_next;
    logic [7:0]          tx_data_reg, tx_data_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [7:0]          mem_wdata_reg, mem_wdata_next;
    logic                mem_we_reg, mem_we_next;
    logic                proc_start_reg, proc_start_next;

    logic                rx_edge;
    logic [ADDR_W:0]     count_inc;
    logic [ADDR_W:0]     idx_inc;

    assign rx_edge   = rx_ready & ~rx_prev_reg;
    assign count_inc = count_reg + ONE;
    assign idx_inc   = idx_reg + ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            rx_prev_reg    <= 1'b0;
            count_reg      <= '0;
            idx_reg        <= '0;
            guard_reg      <= '0;
            tx_wr_en_reg   <= 1'b0;
            tx_data_reg    <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_we_reg     <= 1'b0;
            proc_start_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rx_prev_reg    <= rx_ready;
            count_reg      <= count_next;
            idx_reg        <= idx_next;
            guard_reg      <= guard_next;
            tx_wr_en_reg   <= tx_wr_en_next;
            tx_data_reg    <= tx_data_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_we_reg     <= mem_we_next;
            proc_start_reg <= proc_start_next;
        end
    end

    // Strobes default low; address/data registers hold so read data stays valid.
    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        idx_next        = idx_reg;
        guard_next      = guard_reg;
        tx_data_next    = tx_data_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        tx_wr_en_next   = 1'b0;
        mem_we_next     = 1'b0;
        proc_start_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_edge) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = '0;
                    mem_wdata_next = rx_data;
                    count_next     = ONE;
                    if (RX_N == ONE) begin
                        state_next      = PROC;
                        proc_start_next = 1'b1;
                    end else begin
                        state_next = RX_LOAD;
                    end
                end
            end
            RX_LOAD: begin
                if (rx_edge) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = count_reg[ADDR_W-1:0];
                    mem_wdata_next = rx_data;
                    count_next     = count_inc;
                    if (count_inc == RX_N) begin
                        state_next      = PROC;
                        proc_start_next = 1'b1;
                    end
                end
            end
            PROC: begin
                if (proc_done) begin
                    state_next    = TX_FETCH;
                    idx_next      = '0;
                    mem_addr_next = TX_BASE_A;
                end
            end
            TX_FETCH: begin
                state_next = TX_SEND;
            end
            TX_SEND: begin
                if (!tx_busy) begin
                    tx_data_next  = mem_rdata;
                    tx_wr_en_next = 1'b1;
                    guard_next    = '0;
                    state_next    = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // The transmitter may take a cycle or two to raise busy after a strobe.
                if (guard_reg != 2'd2) begin
                    guard_next = guard_reg + 2'd1;
                end else if (!tx_busy) begin
                    idx_next = idx_inc;
                    if (idx_inc == TX_N) begin
                        state_next = IDLE;
                        count_next = '0;
                    end else begin
                        state_next    = TX_FETCH;
                        mem_addr_next = TX_BASE_A + idx_inc[ADDR_W-1:0];
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx_wr_en   = tx_wr_en_reg;
    assign tx_data    = tx_data_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign mem_we     = mem_we_reg;
    assign proc_start = proc_start_reg;
    assign phase      = state_reg;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Scoreboard bench for uart_mem_bridge: stimulus pushes expected writes/transmits,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_uart_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_busy = 1'b0;
    logic        tx_wr_en;
    logic [7:0]  tx_data;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata = 8'h00;
    logic        proc_start;
    logic        proc_done;
    logic [2:0]  phase;

    uart_mem_bridge #(
        .ADDR_W(16), .RX_BYTES(4), .TX_BYTES(2), .TX_BASE(8)
    ) dut (
        .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_wr_en(tx_wr_en), .tx_data(tx_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .proc_start(proc_start), .proc_done(proc_done),
        .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];
    int         total = 0;
    int         bad = 0;
    int         starts = 0;
    int         busy_len = 3;
    int         busy_left = 0;
    logic       start_prev = 1'b0;

    // Result memory: only the transmit window holds known content.
    always @(posedge clk) begin
        mem_rdata <= (mem_addr == 16'd8) ? 8'hA5 : (mem_addr == 16'd9) ? 8'h5A : 8'h00;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            start_prev <= 1'b0;
        end else begin
            if (mem_we && tx_wr_en) chk("we_and_tx_same_cycle", 1, 0);
            if (mem_we) begin
                $display("wr   addr=%0h data=%0h", mem_addr, mem_wdata);
                if (wr_q.size() == 0) begin
                    chk("unexpected_write_addr", {48'd0, mem_addr}, 64'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_wdata, e.d);
                end
            end
            if (tx_wr_en) begin
                $display("tx   data=%0h", tx_data);
                chk("strobe_while_busy", tx_busy, 0);
                if (tx_q.size() == 0) begin
                    chk("unexpected_tx", {56'd0, tx_data}, 64'hFFFF);
                end else begin
                    logic [7:0] t;
                    t = tx_q.pop_front();
                    chk("tx_data", tx_data, t);
                end
                tx_busy   <= 1'b1;
                busy_left <= busy_len;
            end else if (busy_left > 1) begin
                busy_left <= busy_left - 1;
            end else if (busy_left == 1) begin
                busy_left <= 0;
                tx_busy   <= 1'b0;
            end
            if (proc_start) begin
                $display("proc_start");
                starts++;
                if (start_prev) chk("proc_start_width", 2, 1);
            end
            start_prev <= proc_start;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold, input bit expect_wr,
                             input logic [15:0] a);
        if (expect_wr) wr_q.push_back('{a: a, d: b});
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (hold) @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_phase(input logic [2:0] p, input int lim, input string nm);
        for (int i = 0; i < lim && phase != p; i++) @(negedge clk);
        chk(nm, phase, p);
    endtask

    task automatic finish_frame(input bit proc_byte);
        wait_phase(3'd2, 50, "phase_proc");
        if (proc_byte) send_byte(8'hEE, 2, 1'b0, 16'd0);
        repeat (10) @(negedge clk);
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h5A);
        proc_done = 1'b1;
        @(negedge clk);
        proc_done = 1'b0;
        wait_phase(3'd0, 2000, "phase_idle_after_tx");
    endtask

    initial begin
        reset     = 1'b1;
        rx_ready  = 1'b0;
        rx_data   = 8'h00;
        proc_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {tx_wr_en, tx_data, mem_addr, mem_wdata, mem_we, proc_start, phase}, 0);
        reset = 1'b0;

        // Frame 1: rx_ready held 5 cycles per byte.
        send_byte(8'h11, 5, 1'b1, 16'd0);
        chk("phase_rx_load", phase, 3'd1);
        send_byte(8'h22, 5, 1'b1, 16'd1);
        send_byte(8'h33, 5, 1'b1, 16'd2);
        send_byte(8'h44, 5, 1'b1, 16'd3);
        finish_frame(1'b0);

        // Frame 2: long transmitter busy, plus a byte dropped during PROC.
        busy_len = 20;
        send_byte(8'h01, 1, 1'b1, 16'd0);
        send_byte(8'h02, 1, 1'b1, 16'd1);
        send_byte(8'h03, 1, 1'b1, 16'd2);
        send_byte(8'h04, 1, 1'b1, 16'd3);
        finish_frame(1'b1);
        busy_len = 3;

        // Frame 3: reset after two bytes, then a full new frame from address 0.
        send_byte(8'h55, 2, 1'b1, 16'd0);
        send_byte(8'h66, 2, 1'b1, 16'd1);
        chk("phase_before_reset", phase, 3'd1);
        #3 reset = 1'b1;
        #1 chk("async_reset_outputs",
               {tx_wr_en, tx_data, mem_addr, mem_wdata, mem_we, proc_start, phase}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_byte(8'h77, 2, 1'b1, 16'd0);
        send_byte(8'h88, 2, 1'b1, 16'd1);
        send_byte(8'h99, 2, 1'b1, 16'd2);
        send_byte(8'hAA, 2, 1'b1, 16'd3);
        finish_frame(1'b0);

        repeat (5) @(negedge clk);
        chk("writes_outstanding", wr_q.size(), 0);
        chk("tx_outstanding", tx_q.size(), 0);
        chk("proc_start_count", starts, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
